f_pc_predictor: RTL and testbench

Parametrised fetch-stage PC predictor for the Y86 pipeline. Each cycle it registers the next predicted fetch address from the current instruction. Jumps and calls are predicted taken, and returns are predicted through a circular return-address stack (RAS). Adds stall hold, redirect from later pipeline stages, and configurable address width and RAS depth.

---
 rtl/f_pc_predictor.sv | 122 ++++++++++++
 tb/tb_f_pc_predictor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_pc_predictor.sv
// f_pc_predictor: fetch-stage next-PC predictor with a circular return-address stack.
// Jumps and calls are predicted taken. Returns pop the RAS. Later-stage redirects
// (ret_resolve_i over mispredict_i) override stall and bubble.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_i, f_valid_i       hold PC/RAS when stalled or on a bubble
//   f_icode_i, f_valC_i,
//   f_valP_i                 fetched instruction fields
//   mispredict_i/_pc_i       jump resolved not-taken, with the correct PC
//   ret_resolve_i/ret_pc_i   ret completed, with the architectural return address
//   F_predPC_o               registered predicted PC
//   ras_count_o, ras_empty_o RAS occupancy
//   ras_overflow_o           one-cycle pulse when a push overwrote the oldest entry
module f_pc_predictor #(
    parameter int unsigned         ADDR_W    = 48,
    parameter int unsigned         RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall_i,
    input  logic                             f_valid_i,
    input  logic [3:0]                       f_icode_i,
    input  logic [ADDR_W-1:0]                f_valC_i,
    input  logic [ADDR_W-1:0]                f_valP_i,
    input  logic                             mispredict_i,
    input  logic [ADDR_W-1:0]                mispredict_pc_i,
    input  logic                             ret_resolve_i,
    input  logic [ADDR_W-1:0]                ret_pc_i,
    output logic [ADDR_W-1:0]                F_predPC_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o,
    output logic                             ras_empty_o,
    output logic                             ras_overflow_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              push_en;

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    // Next-PC selection and RAS pointer/count update
    always_comb begin
        pc_d    = pc_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        push_en = 1'b0;

        if (ret_resolve_i) begin
            pc_d = ret_pc_i;
        end else if (mispredict_i) begin
            pc_d = mispredict_pc_i;
        end else if (!stall_i && f_valid_i) begin
            case (f_icode_i)
                IJXX: begin
                    pc_d = f_valC_i;
                end
                ICALL: begin
                    pc_d    = f_valC_i;
                    push_en = 1'b1;
                    top_d   = top_q + PTR_W'(1);
                    // Full stack: the new top lands on the oldest entry
                    if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                IRET: begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[top_q];
                        top_d = top_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d = f_valP_i;
                    end
                end
                default: begin
                    pc_d = f_valP_i;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // RAS storage; contents survive reset, only pointer and count are cleared
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            ras_q[top_d] <= f_valP_i;
        end
    end

    assign F_predPC_o     = pc_q;
    assign ras_count_o    = cnt_q;
    assign ras_empty_o    = (cnt_q == '0);
    assign ras_overflow_o = ovf_q;

endmodule

// File: tb/tb_f_pc_predictor.sv
// Bench for f_pc_predictor: directed scenarios plus random stimulus checked against
// a queue-based model (a bounded stack that drops its oldest entry when full).
module tb_f_pc_predictor;

    localparam int unsigned ADDR_W    = 48;
    localparam int unsigned RAS_DEPTH = 8;
    localparam int unsigned CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RST_PC = 48'h100;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_i;
    logic              f_valid_i;
    logic [3:0]        f_icode_i;
    logic [ADDR_W-1:0] f_valC_i;
    logic [ADDR_W-1:0] f_valP_i;
    logic              mispredict_i;
    logic [ADDR_W-1:0] mispredict_pc_i;
    logic              ret_resolve_i;
    logic [ADDR_W-1:0] ret_pc_i;
    logic [ADDR_W-1:0] F_predPC_o;
    logic [CNT_W-1:0]  ras_count_o;
    logic              ras_empty_o;
    logic              ras_overflow_o;

    f_pc_predictor #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .f_valid_i      (f_valid_i),
        .f_icode_i      (f_icode_i),
        .f_valC_i       (f_valC_i),
        .f_valP_i       (f_valP_i),
        .mispredict_i   (mispredict_i),
        .mispredict_pc_i(mispredict_pc_i),
        .ret_resolve_i  (ret_resolve_i),
        .ret_pc_i       (ret_pc_i),
        .F_predPC_o     (F_predPC_o),
        .ras_count_o    (ras_count_o),
        .ras_empty_o    (ras_empty_o),
        .ras_overflow_o (ras_overflow_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_ras[$];
    logic              m_ovf;

    function automatic logic [ADDR_W-1:0] rand_addr();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Apply the prediction rules to the inputs present at the last edge
    function automatic void model_apply();
        m_ovf = 1'b0;
        if (rst) begin
            m_pc = RST_PC;
            m_ras.delete();
        end else if (ret_resolve_i) begin
            m_pc = ret_pc_i;
        end else if (mispredict_i) begin
            m_pc = mispredict_pc_i;
        end else if (!stall_i && f_valid_i) begin
            if (f_icode_i == 4'h7) begin
                m_pc = f_valC_i;
            end else if (f_icode_i == 4'h8) begin
                m_pc = f_valC_i;
                m_ras.push_back(f_valP_i);
                if (m_ras.size() > RAS_DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end else if (f_icode_i == 4'h9 && m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc = f_valP_i;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_apply();
    endtask

    task automatic set_idle();
        rst = 1'b0; stall_i = 1'b0; f_valid_i = 1'b0; f_icode_i = 4'h0;
        f_valC_i = '0; f_valP_i = '0; mispredict_i = 1'b0; mispredict_pc_i = '0;
        ret_resolve_i = 1'b0; ret_pc_i = '0;
    endtask

    task automatic set_instr(input logic [3:0] ic, input logic [ADDR_W-1:0] c,
                             input logic [ADDR_W-1:0] p);
        f_valid_i = 1'b1; f_icode_i = ic; f_valC_i = c; f_valP_i = p;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        set_instr(4'h8, 48'h999, 48'h998);
        step();
        total++;
        if (F_predPC_o !== 48'h100) begin bad++; $display("FAIL reset_pc got=%h exp=%h", F_predPC_o, 48'h100); end
        total++;
        if (ras_count_o !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ras_count_o); end
        total++;
        if (ras_empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", ras_empty_o); end
        total++;
        if (ras_overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ras_overflow_o); end
        set_idle();
    endtask

    task automatic test_call_ret();
        set_idle();
        set_instr(4'h8, 48'h40, 48'h0A);
        step();
        total++;
        if (F_predPC_o !== 48'h40 || ras_count_o !== CNT_W'(1)) begin
            bad++; $display("FAIL call pc=%h cnt=%0d exp pc=40 cnt=1", F_predPC_o, ras_count_o);
        end
        set_instr(4'h9, 48'h0, 48'h41);
        step();
        total++;
        if (F_predPC_o !== 48'h0A || ras_count_o !== '0 || ras_empty_o !== 1'b1) begin
            bad++; $display("FAIL ret pc=%h cnt=%0d empty=%b exp pc=0a cnt=0 empty=1",
                            F_predPC_o, ras_count_o, ras_empty_o);
        end
        set_idle();
    endtask

    task automatic test_overflow();
        set_idle();
        for (int i = 1; i <= 9; i++) begin
            set_instr(4'h8, 48'h1000 + ADDR_W'(i), ADDR_W'(i));
            step();
            total++;
            if (ras_overflow_o !== (i == 9)) begin
                bad++; $display("FAIL ovf_push%0d got=%b exp=%b", i, ras_overflow_o, (i == 9));
            end
            total++;
            if (ras_count_o !== CNT_W'((i > 8) ? 8 : i)) begin
                bad++; $display("FAIL ovf_count%0d got=%0d exp=%0d", i, ras_count_o, (i > 8) ? 8 : i);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            set_instr(4'h9, 48'h0, 48'h500 + ADDR_W'(i));
            step();
            total++;
            if (i <= 8) begin
                if (F_predPC_o !== ADDR_W'(10 - i) || ras_overflow_o !== 1'b0) begin
                    bad++; $display("FAIL ovf_pop%0d got=%h exp=%h ovf=%b", i, F_predPC_o, 10 - i, ras_overflow_o);
                end
            end else begin
                if (F_predPC_o !== 48'h509 || ras_count_o !== '0) begin
                    bad++; $display("FAIL empty_ret got=%h cnt=%0d exp=509 cnt=0", F_predPC_o, ras_count_o);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_stall_redirect();
        logic [ADDR_W-1:0] held;
        set_idle();
        held = m_pc;
        stall_i = 1'b1;
        set_instr(4'h7, 48'h200, 48'h201);
        step();
        total++;
        if (F_predPC_o !== held) begin bad++; $display("FAIL stall_hold got=%h exp=%h", F_predPC_o, held); end
        mispredict_i = 1'b1; mispredict_pc_i = 48'h15;
        step();
        total++;
        if (F_predPC_o !== 48'h15) begin bad++; $display("FAIL stall_redirect got=%h exp=15", F_predPC_o); end
        set_idle();
    endtask

    task automatic test_both_redirect();
        set_idle();
        set_instr(4'h8, 48'h60, 48'h61);
        step();
        set_instr(4'h8, 48'h70, 48'h71);
        mispredict_i = 1'b1; mispredict_pc_i = 48'h15;
        ret_resolve_i = 1'b1; ret_pc_i = 48'h33;
        step();
        total++;
        if (F_predPC_o !== 48'h33 || ras_count_o !== CNT_W'(1)) begin
            bad++; $display("FAIL both_redirect pc=%h cnt=%0d exp pc=33 cnt=1", F_predPC_o, ras_count_o);
        end
        set_idle();
    endtask

    task automatic test_bubble();
        set_idle();
        set_instr(4'h8, 48'h80, 48'h81);
        f_valid_i = 1'b0;
        step();
        total++;
        if (F_predPC_o !== 48'h33 || ras_count_o !== CNT_W'(1)) begin
            bad++; $display("FAIL bubble pc=%h cnt=%0d exp pc=33 cnt=1", F_predPC_o, ras_count_o);
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [3:0] ic_pick [5];
        ic_pick = '{4'h7, 4'h8, 4'h9, 4'h9, 4'h6};
        for (int n = 0; n < 600; n++) begin
            set_idle();
            rst           = ($urandom_range(0, 99) == 0);
            stall_i       = ($urandom_range(0, 9) == 0);
            f_valid_i     = ($urandom_range(0, 9) != 0);
            mispredict_i  = ($urandom_range(0, 14) == 0);
            ret_resolve_i = ($urandom_range(0, 19) == 0);
            f_icode_i     = ($urandom_range(0, 5) == 5) ? 4'($urandom) : ic_pick[$urandom_range(0, 4)];
            f_valC_i      = rand_addr();
            f_valP_i      = rand_addr();
            mispredict_pc_i = rand_addr();
            ret_pc_i      = rand_addr();
            step();
            total++;
            if (F_predPC_o !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, F_predPC_o, m_pc); end
            total++;
            if (ras_count_o !== CNT_W'(m_ras.size())) begin
                bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, ras_count_o, m_ras.size());
            end
            total++;
            if (ras_empty_o !== (m_ras.size() == 0)) begin
                bad++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, ras_empty_o, (m_ras.size() == 0));
            end
            total++;
            if (ras_overflow_o !== m_ovf) begin
                bad++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, ras_overflow_o, m_ovf);
            end
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        set_idle();
        set_instr(4'h8, 48'hA0, 48'hA1);
        step();
        rst = 1'b1;
        set_instr(4'h8, 48'hB0, 48'hB1);
        ret_resolve_i = 1'b1; ret_pc_i = 48'h77;
        step();
        total++;
        if (F_predPC_o !== 48'h100 || ras_count_o !== '0 || ras_overflow_o !== 1'b0) begin
            bad++; $display("FAIL reset_mid pc=%h cnt=%0d ovf=%b exp pc=100 cnt=0 ovf=0",
                            F_predPC_o, ras_count_o, ras_overflow_o);
        end
        set_idle();
    endtask

    initial begin
        m_pc  = '0;
        m_ovf = 1'b0;
        test_reset();
        test_call_ret();
        test_overflow();
        test_stall_redirect();
        test_both_redirect();
        test_bubble();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
